// File: rtl/zero_scan_pkg.sv
// Shared definitions for the zero-scan unit: FSM encoding and a constant clog2.
package zero_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/zero_scan_unit_chunk_prio_enc.sv
// Combinational chunk encoder: balanced OR-tree "any" plus local first-set-bit index.
// Zero latency, no handshake; scan direction chosen by msb_first_i.
module chunk_prio_enc
  import zero_scan_pkg::*;
#(
  parameter int CHUNK = 8,
  localparam int LIDX_W = (clog2(CHUNK) > 0) ? clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0]  bits_i,
  input  logic              msb_first_i,
  output logic              any_o,
  output logic [LIDX_W-1:0] idx_o
);

  logic [CHUNK-1:0] tree;

  // Pairwise in-place halving: each pass is one level of two-input ORs.
  always_comb begin
    tree = bits_i;
    for (int w = CHUNK; w > 1; w = w / 2) begin
      for (int j = 0; j < w / 2; j++) begin
        tree[j] = tree[2*j] | tree[2*j+1];
      end
    end
    any_o = tree[0];
  end

  always_comb begin
    idx_o = '0;
    if (msb_first_i) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (bits_i[i]) idx_o = LIDX_W'(i);
      end
    end else begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (bits_i[i]) idx_o = LIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/zero_scan_unit.sv
// Multi-cycle zero detector / first-set-bit finder, CHUNK bits per cycle, early exit.
// Latency: 1 accept cycle + (k+1) scan cycles; result held in DONE until out_ready, no accept meanwhile.
module zero_scan_unit
  import zero_scan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int IDX_W = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_nonzero,
  output logic             out_zero,
  output logic [IDX_W-1:0] out_index
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W      = (clog2(NUM_CHUNKS) > 0) ? clog2(NUM_CHUNKS) : 1;
  localparam int LIDX_W     = (clog2(CHUNK) > 0) ? clog2(CHUNK) : 1;
  localparam int LSH        = clog2(CHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic              msb_q, msb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nonzero_q, nonzero_d;
  logic [IDX_W-1:0]  index_q, index_d;

  logic [CNT_W-1:0]  sel_chunk;
  logic [IDX_W-1:0]  base_idx;
  logic [CHUNK-1:0]  chunk_bits;
  logic              chunk_any;
  logic [LIDX_W-1:0] local_idx;
  logic [IDX_W-1:0]  abs_idx;

  // MSB mode walks the chunks from the top, so the physical chunk is mirrored.
  assign sel_chunk  = msb_q ? (LAST_CNT - cnt_q) : cnt_q;
  assign base_idx   = IDX_W'(sel_chunk) << LSH;
  assign chunk_bits = op_q[base_idx +: CHUNK];
  assign abs_idx    = base_idx + IDX_W'(local_idx);

  chunk_prio_enc #(
    .CHUNK(CHUNK)
  ) u_enc (
    .bits_i      (chunk_bits),
    .msb_first_i (msb_q),
    .any_o       (chunk_any),
    .idx_o       (local_idx)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    msb_d     = msb_q;
    cnt_d     = cnt_q;
    nonzero_d = nonzero_q;
    index_d   = index_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = in_data;
          msb_d     = in_msb_first;
          cnt_d     = '0;
          nonzero_d = 1'b0;
          index_d   = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (chunk_any) begin
          nonzero_d = 1'b1;
          index_d   = abs_idx;
          state_d   = DONE;
        end else if (cnt_q == LAST_CNT) begin
          nonzero_d = 1'b0;
          index_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      msb_q     <= 1'b0;
      cnt_q     <= '0;
      nonzero_q <= 1'b0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      msb_q     <= msb_d;
      cnt_q     <= cnt_d;
      nonzero_q <= nonzero_d;
      index_q   <= index_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_nonzero = nonzero_q;
  assign out_zero    = ~nonzero_q;
  assign out_index   = index_q;

endmodule
